// File: rtl/clock_pkg.sv
// Shared encodings, field widths and default moduli for the
// time-of-day clock and its setting FSM.
package clock_pkg;

  localparam int HOURS_MOD_DEF   = 24;
  localparam int MINUTES_MOD_DEF = 60;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10,
    MODE_BAD      = 2'b11
  } mode_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear and a wrap carry.
// carry is combinational: high on the increment that wraps to 0.
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  logic         at_max;

  // >= keeps any out-of-range value wrapping back to 0
  assign at_max = (value_q >= MAX);
  assign carry  = inc & ~clear & at_max;
  assign value  = value_q;

  // next value: clear beats increment
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/clock_time_set.sv
// Time-of-day clock with RUN / SET_HOUR / SET_MIN mode FSM and
// a blink enable for the field currently being edited.
module clock_time_set
  import clock_pkg::*;
#(
  parameter int HOURS_MOD   = HOURS_MOD_DEF,
  parameter int MINUTES_MOD = MINUTES_MOD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              mode_pulse,
  input  logic              inc_pulse,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [1:0]        set_mode,
  output logic              blink
);

  mode_e state_q;
  mode_e state_d;
  logic  blink_q;
  logic  blink_d;

  logic in_run;
  logic in_hour;
  logic in_min;
  logic edit;

  logic sec_inc;
  logic min_inc;
  logic hr_inc;
  logic sec_clr;
  logic sec_carry;
  logic min_carry;

  assign in_run  = (state_q == MODE_RUN);
  assign in_hour = (state_q == MODE_SET_HOUR);
  assign in_min  = (state_q == MODE_SET_MIN);

  // mode wins over inc on the same edge
  assign edit = inc_pulse & ~mode_pulse;

  // time only runs in RUN; set modes bump one field, no carry
  assign sec_inc = in_run & tick_1hz;
  assign min_inc = (in_run & sec_carry)
                 | (in_min & edit);
  assign hr_inc  = (in_run & min_carry)
                 | (in_hour & edit);

  // leaving SET_MIN restarts the clock at hh:mm:00
  assign sec_clr = in_min & mode_pulse;

  mod_counter #(
    .MOD (MINUTES_MOD),
    .W   (SEC_W)
  ) u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_inc),
    .clear (sec_clr),
    .value (seconds),
    .carry (sec_carry)
  );

  mod_counter #(
    .MOD (MINUTES_MOD),
    .W   (MIN_W)
  ) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (min_inc),
    .clear (1'b0),
    .value (minutes),
    .carry (min_carry)
  );

  mod_counter #(
    .MOD (HOURS_MOD),
    .W   (HOUR_W)
  ) u_hr (
    .clk   (clk),
    .reset (reset),
    .inc   (hr_inc),
    .clear (1'b0),
    .value (hours),
    .carry ()
  );

  // next mode and blink; entering a set mode starts blink dark
  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    unique case (state_q)
      MODE_RUN: begin
        blink_d = 1'b1;
        if (mode_pulse) begin
          state_d = MODE_SET_HOUR;
          blink_d = 1'b0;
        end
      end
      MODE_SET_HOUR: begin
        if (mode_pulse) begin
          state_d = MODE_SET_MIN;
          blink_d = 1'b0;
        end else if (inc_pulse) begin
          blink_d = 1'b1;
        end else if (tick_1hz) begin
          blink_d = ~blink_q;
        end
      end
      MODE_SET_MIN: begin
        if (mode_pulse) begin
          state_d = MODE_RUN;
          blink_d = 1'b1;
        end else if (inc_pulse) begin
          blink_d = 1'b1;
        end else if (tick_1hz) begin
          blink_d = ~blink_q;
        end
      end
      default: begin
        state_d = MODE_RUN;
        blink_d = 1'b1;
      end
    endcase
  end

  // mode and blink registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MODE_RUN;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
    end
  end

  assign set_mode = state_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clock_time_set.sv
// Self-checking bench for clock_time_set: hand-written vector
// table, directed corner sequences and a random run vs a model.
module tb_clock_time_set;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       mode_pulse = 1'b0;
  logic       inc_pulse = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] set_mode;
  logic       blink;

  always #10 clk = ~clk;

  clock_time_set dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .mode_pulse (mode_pulse),
    .inc_pulse  (inc_pulse),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .set_mode   (set_mode),
    .blink      (blink)
  );

  typedef struct packed {
    logic       r;
    logic       t;
    logic       md;
    logic       in;
    logic [19:0] exp;
  } vec_t;

  int checks = 0;
  int passed = 0;

  logic [19:0] sb_q[$];
  logic [19:0] act;
  vec_t        tv[$];

  int mh = 0;
  int mm = 0;
  int ms = 0;
  int mmode = 0;
  bit mbl = 1'b1;

  assign act = {hours, minutes, seconds, set_mode, blink};

  function automatic logic [19:0] pack(int h, int m, int s,
                                       int sm, bit b);
    return {5'(h), 6'(m), 6'(s), 2'(sm), b};
  endfunction

  function automatic vec_t mk(bit r, bit t, bit md, bit in,
                              int h, int m, int s, int sm, bit b);
    vec_t v;
    v.r   = r;
    v.t   = t;
    v.md  = md;
    v.in  = in;
    v.exp = pack(h, m, s, sm, b);
    return v;
  endfunction

  task automatic check(input string nm, input logic [19:0] got,
                       input logic [19:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0b, expected %0d:%0d:%0d mode=%0d blink=%0b",
               nm, got[19:15], got[14:9], got[8:3], got[2:1], got[0],
               exp[19:15], exp[14:9], exp[8:3], exp[2:1], exp[0]);
    end
  endtask

  // reference model of one clock edge
  task automatic model_step(input bit r, input bit t,
                            input bit md, input bit in);
    if (r) begin
      mh = 0; mm = 0; ms = 0; mmode = 0; mbl = 1'b1;
    end else if (mmode == 0) begin
      if (t) begin
        ms = ms + 1;
        if (ms == 60) begin
          ms = 0;
          mm = mm + 1;
          if (mm == 60) begin
            mm = 0;
            mh = (mh + 1) % 24;
          end
        end
      end
      if (md) begin
        mmode = 1; mbl = 1'b0;
      end else begin
        mbl = 1'b1;
      end
    end else if (mmode == 1) begin
      if (md) begin
        mmode = 2; mbl = 1'b0;
      end else if (in) begin
        mh = (mh + 1) % 24; mbl = 1'b1;
      end else if (t) begin
        mbl = ~mbl;
      end
    end else begin
      if (md) begin
        mmode = 0; ms = 0; mbl = 1'b1;
      end else if (in) begin
        mm = (mm + 1) % 60; mbl = 1'b1;
      end else if (t) begin
        mbl = ~mbl;
      end
    end
  endtask

  // drive one cycle, queue its expectation, compare after edge
  task automatic drive(input bit r, input bit t, input bit md,
                       input bit in, input logic [19:0] exp,
                       input string nm);
    logic [19:0] e;
    @(negedge clk);
    reset      = r;
    tick_1hz   = t;
    mode_pulse = md;
    inc_pulse  = in;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      check(nm, act, e);
    end
  endtask

  task automatic step(input bit r, input bit t, input bit md,
                      input bit in, input string nm);
    model_step(r, t, md, in);
    drive(r, t, md, in, pack(mh, mm, ms, mmode, mbl), nm);
  endtask

  task automatic steps(input int n, input bit t, input bit md,
                       input bit in, input string nm);
    for (int i = 0; i < n; i++) begin
      step(1'b0, t, md, in, nm);
    end
  endtask

  initial begin
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1));
    tv.push_back(mk(0, 1, 1, 0, 0, 0, 2, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 1));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 2, 1, 1));
    tv.push_back(mk(0, 0, 1, 1, 1, 0, 2, 2, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 1, 2, 2, 1));
    tv.push_back(mk(0, 1, 0, 1, 1, 2, 2, 2, 1));
    tv.push_back(mk(0, 1, 0, 0, 1, 2, 2, 2, 0));
    tv.push_back(mk(0, 0, 1, 0, 1, 2, 0, 0, 1));
    tv.push_back(mk(0, 1, 0, 0, 1, 2, 1, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 1, 2, 1, 0, 1));
    tv.push_back(mk(0, 1, 0, 1, 1, 2, 2, 0, 1));
    tv.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 1));

    foreach (tv[i]) begin
      model_step(tv[i].r, tv[i].t, tv[i].md, tv[i].in);
      drive(tv[i].r, tv[i].t, tv[i].md, tv[i].in, tv[i].exp,
            $sformatf("vec%0d", i));
    end

    // 61 ticks from reset
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst_a");
    steps(61, 1'b1, 1'b0, 1'b0, "tick61");
    check("after_61_ticks", act, pack(0, 1, 1, 0, 1));

    // preload 23:59:58, then full-day wrap
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst_b");
    steps(1, 1'b0, 1'b1, 1'b0, "pre_mode1");
    steps(23, 1'b0, 1'b0, 1'b1, "pre_hr");
    steps(1, 1'b0, 1'b1, 1'b0, "pre_mode2");
    steps(59, 1'b0, 1'b0, 1'b1, "pre_min");
    steps(1, 1'b0, 1'b1, 1'b0, "pre_mode3");
    steps(58, 1'b1, 1'b0, 1'b0, "pre_sec");
    steps(1, 1'b1, 1'b0, 1'b0, "wrap_t1");
    check("at_235959", act, pack(23, 59, 59, 0, 1));
    steps(1, 1'b1, 1'b0, 1'b0, "wrap_t2");
    check("wrap_000000", act, pack(0, 0, 0, 0, 1));

    // 25 incs in SET_HOUR with ticks mixed in
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst_c");
    steps(5, 1'b1, 1'b0, 1'b0, "c_tick");
    steps(1, 1'b0, 1'b1, 1'b0, "c_mode");
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, "c_inc");
      if (i % 8 == 3) begin
        step(1'b0, 1'b1, 1'b0, 1'b0, "c_tick_set");
      end
    end
    check("hour_wrap_25", act, pack(1, 0, 5, 1, 1));

    // held inc counts every cycle
    steps(3, 1'b0, 1'b0, 1'b1, "held_inc");
    check("held_inc_3", act, pack(4, 0, 5, 1, 1));

    // minutes to 59, exit clears seconds
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst_d");
    steps(37, 1'b1, 1'b0, 1'b0, "d_tick");
    steps(1, 1'b0, 1'b1, 1'b0, "d_mode1");
    check("sec_kept_37", act, pack(0, 0, 37, 1, 0));
    steps(1, 1'b0, 1'b1, 1'b0, "d_mode2");
    steps(59, 1'b0, 1'b0, 1'b1, "d_inc");
    steps(1, 1'b0, 1'b1, 1'b0, "d_mode3");
    check("exit_setmin", act, pack(0, 59, 0, 0, 1));

    // mode+inc together, then blink toggles on ticks
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst_e");
    step(1'b0, 1'b0, 1'b1, 1'b1, "e_mode_inc");
    check("mode_beats_inc", act, pack(0, 0, 0, 1, 0));
    step(1'b0, 1'b1, 1'b0, 1'b0, "e_tick1");
    check("blink_on", act, pack(0, 0, 0, 1, 1));
    step(1'b0, 1'b1, 1'b0, 1'b0, "e_tick2");
    check("blink_off", act, pack(0, 0, 0, 1, 0));

    // reset mid-edit at 12:34:56
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst_f");
    steps(56, 1'b1, 1'b0, 1'b0, "f_tick");
    steps(1, 1'b0, 1'b1, 1'b0, "f_mode1");
    steps(12, 1'b0, 1'b0, 1'b1, "f_hr");
    steps(1, 1'b0, 1'b1, 1'b0, "f_mode2");
    steps(34, 1'b0, 1'b0, 1'b1, "f_min");
    check("at_123456", act, pack(12, 34, 56, 2, 1));
    step(1'b1, 1'b1, 1'b1, 1'b1, "f_reset");
    check("reset_mid_edit", act, pack(0, 0, 0, 0, 1));

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 60) == 0, ($urandom % 3) == 0,
           ($urandom % 10) == 0, ($urandom % 3) == 0, "rand");
    end

    @(negedge clk);
    tick_1hz   = 1'b0;
    mode_pulse = 1'b0;
    inc_pulse  = 1'b0;
    reset      = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
